// File: rtl/regfile_read_arbiter.sv
// Round-robin share of the register file's two read ports between issue (0) and debug (1).
// Response one cycle after grant; grants stall while the held response is not accepted.
module regfile_read_arbiter #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*ADDR_W-1:0] req_rs1,
   input  logic [2*ADDR_W-1:0] req_rs2,
   output logic [1:0]          resp_valid,
   input  logic [1:0]          resp_ready,
   output logic [DATA_W-1:0]   resp_data1,
   output logic [DATA_W-1:0]   resp_data2,
   output logic [ADDR_W-1:0]   rf_rs1,
   output logic [ADDR_W-1:0]   rf_rs2,
   input  logic [DATA_W-1:0]   rf_rdata1,
   input  logic [DATA_W-1:0]   rf_rdata2
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t state;
   logic   owner;
   logic   last_grant;
   logic   slot_free;
   logic   gnt_vld;
   logic   winner;

   always_comb begin
      slot_free = (state == IDLE) || (resp_valid[owner] && resp_ready[owner]);
      // On a tie the requester not served last time wins, which forces alternation.
      winner    = (&req_valid) ? ~last_grant : req_valid[1];
      gnt_vld   = reset_n && slot_free && (|req_valid);
      req_ready = 2'b00;
      rf_rs1    = '0;
      rf_rs2    = '0;
      if (gnt_vld) begin
         req_ready[winner] = 1'b1;
         rf_rs1 = winner ? req_rs1[ADDR_W +: ADDR_W] : req_rs1[0 +: ADDR_W];
         rf_rs2 = winner ? req_rs2[ADDR_W +: ADDR_W] : req_rs2[0 +: ADDR_W];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         resp_valid <= 2'b00;
         resp_data1 <= '0;
         resp_data2 <= '0;
      end else if (gnt_vld) begin
         state      <= RESP;
         owner      <= winner;
         last_grant <= winner;
         resp_valid <= winner ? 2'b10 : 2'b01;
         resp_data1 <= rf_rdata1;
         resp_data2 <= rf_rdata2;
      end else if (slot_free) begin
         state      <= IDLE;
         resp_valid <= 2'b00;
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed vector bench for regfile_read_arbiter with a small register file model.
module tb_regfile_read_arbiter;

   localparam logic [63:0] RA  = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] R30 = 64'h0000_0000_0000_0005;
   localparam logic [63:0] R29 = 64'h2929_2929_2929_2929;
   localparam logic [63:0] R28 = 64'h2828_2828_2828_2828;
   localparam logic [63:0] R15 = 64'h1515_1515_1515_1515;
   localparam logic [63:0] R14 = 64'h1414_1414_1414_1414;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [9:0]  req_rs1 = '0;
   logic [9:0]  req_rs2 = '0;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready = 2'b00;
   logic [63:0] resp_data1, resp_data2;
   logic [4:0]  rf_rs1, rf_rs2;
   logic [63:0] rf_rdata1, rf_rdata2;
   logic [63:0] rf [32];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb begin
      rf_rdata1 = rf[rf_rs1];
      rf_rdata2 = rf[rf_rs2];
   end

   regfile_read_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data1(resp_data1), .resp_data2(resp_data2),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  rv;
      logic [4:0]  a1_0, a2_0, a1_1, a2_1;
      logic [1:0]  rr;
      logic [1:0]  e_rqr;
      logic [1:0]  e_rsv;
      logic        chkd;
      logic [63:0] e_d1, e_d2;
      logic [4:0]  e_f1, e_f2;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(logic rst, logic [1:0] rv, logic [4:0] a1_0, logic [4:0] a2_0,
                               logic [4:0] a1_1, logic [4:0] a2_1, logic [1:0] rr,
                               logic [1:0] e_rqr, logic [1:0] e_rsv, logic chkd,
                               logic [63:0] e_d1, logic [63:0] e_d2,
                               logic [4:0] e_f1, logic [4:0] e_f2);
      vec_t v;
      v.rst = rst; v.rv = rv; v.a1_0 = a1_0; v.a2_0 = a2_0; v.a1_1 = a1_1; v.a2_1 = a2_1;
      v.rr = rr; v.e_rqr = e_rqr; v.e_rsv = e_rsv; v.chkd = chkd;
      v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_f1 = e_f1; v.e_f2 = e_f2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 64'(i);
      rf[31] = RA;  rf[30] = R30; rf[29] = R29;
      rf[28] = R28; rf[15] = R15; rf[14] = R14;

      // rst  rv     a1_0 a2_0 a1_1 a2_1 rr     rqr    rsv  chkd d1   d2   f1  f2
      vecs[0]  = mk(0, 2'b01, 31, 30, 0,  0,  2'b01, 2'b00, 2'b00, 1, 0,   0,   0,  0);
      vecs[1]  = mk(1, 2'b01, 31, 30, 0,  0,  2'b01, 2'b01, 2'b00, 1, 0,   0,   31, 30);
      vecs[2]  = mk(1, 2'b00, 31, 30, 0,  0,  2'b01, 2'b00, 2'b01, 1, RA,  R30, 0,  0);
      vecs[3]  = mk(1, 2'b11, 29, 28, 15, 14, 2'b11, 2'b10, 2'b00, 0, 0,   0,   15, 14);
      vecs[4]  = mk(1, 2'b11, 29, 28, 15, 14, 2'b11, 2'b01, 2'b10, 1, R15, R14, 29, 28);
      vecs[5]  = mk(1, 2'b11, 29, 28, 15, 14, 2'b11, 2'b10, 2'b01, 1, R29, R28, 15, 14);
      vecs[6]  = mk(1, 2'b11, 29, 28, 15, 14, 2'b11, 2'b01, 2'b10, 1, R15, R14, 29, 28);
      vecs[7]  = mk(1, 2'b11, 29, 28, 15, 14, 2'b00, 2'b00, 2'b01, 1, R29, R28, 0,  0);
      vecs[8]  = mk(1, 2'b11, 29, 28, 15, 14, 2'b00, 2'b00, 2'b01, 1, R29, R28, 0,  0);
      vecs[9]  = mk(1, 2'b11, 29, 28, 15, 14, 2'b00, 2'b00, 2'b01, 1, R29, R28, 0,  0);
      vecs[10] = mk(1, 2'b11, 29, 28, 15, 14, 2'b01, 2'b10, 2'b01, 1, R29, R28, 15, 14);
      vecs[11] = mk(1, 2'b00, 29, 28, 15, 14, 2'b00, 2'b00, 2'b10, 1, R15, R14, 0,  0);
      vecs[12] = mk(1, 2'b00, 29, 28, 15, 14, 2'b01, 2'b00, 2'b10, 1, R15, R14, 0,  0);
      vecs[13] = mk(1, 2'b01, 0,  0,  15, 14, 2'b10, 2'b01, 2'b10, 1, R15, R14, 0,  0);
      vecs[14] = mk(1, 2'b00, 0,  0,  15, 14, 2'b10, 2'b00, 2'b01, 1, 0,   0,   0,  0);
      vecs[15] = mk(1, 2'b00, 0,  0,  15, 14, 2'b01, 2'b00, 2'b01, 1, 0,   0,   0,  0);
      vecs[16] = mk(1, 2'b00, 0,  0,  15, 14, 2'b00, 2'b00, 2'b00, 0, 0,   0,   0,  0);

      #2 reset_n = 1'b0;

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         reset_n    = vecs[i].rst;
         req_valid  = vecs[i].rv;
         req_rs1    = {vecs[i].a1_1, vecs[i].a1_0};
         req_rs2    = {vecs[i].a2_1, vecs[i].a2_0};
         resp_ready = vecs[i].rr;
         #1;
         chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].e_rqr));
         chk($sformatf("v%0d resp_valid", i), 64'(resp_valid), 64'(vecs[i].e_rsv));
         chk($sformatf("v%0d rf_rs1", i), 64'(rf_rs1), 64'(vecs[i].e_f1));
         chk($sformatf("v%0d rf_rs2", i), 64'(rf_rs2), 64'(vecs[i].e_f2));
         if (vecs[i].chkd) begin
            chk($sformatf("v%0d resp_data1", i), resp_data1, vecs[i].e_d1);
            chk($sformatf("v%0d resp_data2", i), resp_data2, vecs[i].e_d2);
         end
      end

      // Asynchronous reset while a response is held, then first tie after release.
      @(negedge clk);
      req_valid  = 2'b10;
      req_rs1    = {5'd31, 5'd0};
      req_rs2    = {5'd30, 5'd0};
      resp_ready = 2'b00;
      #1 chk("mid grant1", 64'(req_ready), 64'(2'b10));
      @(negedge clk);
      req_valid = 2'b11;
      #1 chk("mid held valid", 64'(resp_valid), 64'(2'b10));
      chk("mid held data1", resp_data1, RA);
      #2 reset_n = 1'b0;
      #1 chk("rst resp_valid", 64'(resp_valid), 64'(2'b00));
      chk("rst req_ready", 64'(req_ready), 64'(2'b00));
      chk("rst data1", resp_data1, 64'h0);
      chk("rst data2", resp_data2, 64'h0);
      @(negedge clk);
      reset_n    = 1'b1;
      req_valid  = 2'b11;
      req_rs1    = {5'd15, 5'd29};
      req_rs2    = {5'd14, 5'd28};
      resp_ready = 2'b11;
      #1 chk("post rst tie", 64'(req_ready), 64'(2'b01));
      chk("post rst rf_rs1", 64'(rf_rs1), 64'(5'd29));
      @(negedge clk);
      #1 chk("post rst resp_valid", 64'(resp_valid), 64'(2'b01));
      chk("post rst data1", resp_data1, R29);
      chk("post rst data2", resp_data2, R28);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
